// File: rtl/lisa_rxn_fifo.sv
// lisa_rxn_fifo: UART receiver with FWFT FIFO and sticky errors; parity built only with LISA_RX_PARITY_EN
module lisa_rxn_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int OVS        = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          baud_ref,
  input  logic                          rxd,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  input  logic                          rd,
  input  logic                          clr_err,
  output logic [DATA_BITS-1:0]          d,
  output logic                          data_avail,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun
);
  localparam int TW = $clog2(OVS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [TW-1:0] MID  = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] FULL = TW'(OVS - 1);
  localparam logic [3:0]    LAST = 4'(DATA_BITS - 1);
`ifdef LISA_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
  state_t state, state_n;
  logic rx_s1, rx_s2, rx_q;
  logic [TW-1:0] tick, tick_n;
  logic [3:0] bits, bits_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic bad, bad_n, pen, pen_n, podd, podd_n;
  logic push, set_fe, set_pe, hit_mid, hit_full;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic push_ok, rd_ok, full;
  assign hit_mid  = baud_ref && tick == MID;
  assign hit_full = baud_ref && tick == FULL;
  // two-flop synchroniser plus one delay flop for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) {rx_s1, rx_s2, rx_q} <= 3'b111;
    else {rx_s1, rx_s2, rx_q} <= {rxd, rx_s1, rx_s2};
  end
  // receiver state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tick  <= '0;
      bits  <= '0;
      sh    <= '0;
      bad   <= 1'b0;
      pen   <= 1'b0;
      podd  <= 1'b0;
    end else begin
      state <= state_n;
      tick  <= tick_n;
      bits  <= bits_n;
      sh    <= sh_n;
      bad   <= bad_n;
      pen   <= pen_n;
      podd  <= podd_n;
    end
  end
  // next-state: tick restarts from 0 on every state entry
  always_comb begin
    state_n = state;
    tick_n  = baud_ref ? tick + 1'b1 : tick;
    bits_n  = bits;
    sh_n    = sh;
    bad_n   = bad;
    pen_n   = pen;
    podd_n  = podd;
    push    = 1'b0;
    set_fe  = 1'b0;
    set_pe  = 1'b0;
    case (state)
      IDLE: begin
        tick_n = '0;
        bits_n = '0;
        bad_n  = 1'b0;
        if (rx_q && !rx_s2) state_n = START;
      end
      START: if (hit_mid) begin
        tick_n  = '0;
        state_n = rx_s2 ? IDLE : DATA;
        pen_n   = PAR & parity_en;
        podd_n  = parity_odd;
      end
      DATA: if (hit_full) begin
        tick_n = '0;
        sh_n   = {rx_s2, sh[DATA_BITS-1:1]};
        bits_n = bits + 4'd1;
        if (bits == LAST) state_n = pen ? PARITY : STOP;
      end
      PARITY: if (hit_full) begin
        tick_n  = '0;
        bad_n   = rx_s2 ^ (^sh) ^ podd;
        state_n = STOP;
      end
      STOP: if (hit_full) begin
        tick_n  = '0;
        state_n = rx_s2 ? IDLE : BRK;
        set_fe  = !rx_s2;
        set_pe  = rx_s2 && bad;
        push    = rx_s2 && !bad;
      end
      BRK: begin
        tick_n = '0;
        if (rx_s2) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  assign full    = count == CW'(FIFO_DEPTH);
  assign rd_ok   = rd && count != '0;
  assign push_ok = push && (!full || rd_ok);
  // FIFO storage; contents need no reset because d is masked while empty
  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= sh;
  end
  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (rd_ok) rp <= rp + 1'b1;
      count <= count + CW'(push_ok) - CW'(rd_ok);
    end
  end
  assign d          = count == '0 ? '0 : mem[rp];
  assign data_avail = count != '0;
  // sticky error flags; a new error beats clr_err in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= set_fe | (frame_err & ~clr_err);
      parity_err <= PAR & (set_pe | (parity_err & ~clr_err));
      overrun    <= (push && full && !rd) | (overrun & ~clr_err);
    end
  end
endmodule

// File: tb/tb_lisa_rxn_fifo.sv
// tb_lisa_rxn_fifo: directed self-checking bench for lisa_rxn_fifo
module tb_lisa_rxn_fifo;
  logic clk = 0, rst = 1, baud_ref, rxd = 1, parity_en = 0, parity_odd = 0, rd = 0, clr_err = 0;
  logic [7:0] d;
  logic data_avail, frame_err, parity_err, overrun;
  logic [2:0] count;
  logic [2:0] bdiv = 0;
  int checks = 0, errors = 0;
  lisa_rxn_fifo dut (
    .clk(clk), .rst(rst), .baud_ref(baud_ref), .rxd(rxd), .parity_en(parity_en),
    .parity_odd(parity_odd), .rd(rd), .clr_err(clr_err), .d(d), .data_avail(data_avail),
    .count(count), .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
  );
  always #5 clk = ~clk;
  always @(posedge clk) bdiv <= bdiv == 3'd4 ? 3'd0 : bdiv + 3'd1;
  assign baud_ref = bdiv == 3'd4;
  task automatic bit_time(input logic v);
    rxd = v;
    repeat (80) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] v, input logic stop_b, input logic use_par, input logic pbit);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(v[i]);
    if (use_par) bit_time(pbit);
    bit_time(stop_b);
  endtask
  task automatic pop(input logic [7:0] exp, input string name);
    checks++;
    if (d !== exp) begin errors++; $display("FAIL %s: d=%h expected %h", name, d, exp); end
    rd = 1;
    @(negedge clk);
    rd = 0;
  endtask
  task automatic clear_errs;
    clr_err = 1;
    @(negedge clk);
    clr_err = 0;
  endtask
  task automatic test_reset;
    repeat (4) @(negedge clk);
    rst = 0;
    @(negedge clk);
    checks++;
    if ({d, data_avail, count, frame_err, parity_err, overrun} !== 15'd0) begin
      errors++;
      $display("FAIL reset: d=%h avail=%b count=%0d fe=%b pe=%b ov=%b expected all 0", d, data_avail, count, frame_err, parity_err, overrun);
    end
  endtask
  task automatic test_single;
    send(8'hA5, 1, 0, 0);
    @(negedge clk);
    checks++;
    if (data_avail !== 1 || count !== 3'd1) begin errors++; $display("FAIL single_avail: avail=%b count=%0d expected 1 1", data_avail, count); end
    pop(8'hA5, "single_d");
    checks++;
    if (data_avail !== 0 || count !== 3'd0) begin errors++; $display("FAIL single_pop: avail=%b count=%0d expected 0 0", data_avail, count); end
  endtask
  task automatic test_overrun;
    for (int i = 1; i <= 5; i++) send(8'(i * 8'h11), 1, 0, 0);
    @(negedge clk);
    checks++;
    if (count !== 3'd4 || overrun !== 1) begin errors++; $display("FAIL overrun_full: count=%0d ov=%b expected 4 1", count, overrun); end
    pop(8'h11, "ovr_pop0");
    pop(8'h22, "ovr_pop1");
    pop(8'h33, "ovr_pop2");
    pop(8'h44, "ovr_pop3");
    checks++;
    if (count !== 3'd0 || overrun !== 1) begin errors++; $display("FAIL overrun_empty: count=%0d ov=%b expected 0 1", count, overrun); end
    pop(8'h00, "underflow_d");
    checks++;
    if (count !== 3'd0) begin errors++; $display("FAIL underflow: count=%0d expected 0", count); end
    clear_errs;
    checks++;
    if (overrun !== 0) begin errors++; $display("FAIL overrun_clr: ov=%b expected 0", overrun); end
  endtask
  task automatic test_break;
    send(8'h3C, 0, 0, 0);
    repeat (20) bit_time(1'b0);
    checks++;
    if (frame_err !== 1 || count !== 3'd0) begin errors++; $display("FAIL break_fe: fe=%b count=%0d expected 1 0", frame_err, count); end
    clear_errs;
    repeat (19) bit_time(1'b0);
    checks++;
    if (frame_err !== 0) begin errors++; $display("FAIL break_once: fe=%b expected 0", frame_err); end
    repeat (2) bit_time(1'b1);
    send(8'h7E, 1, 0, 0);
    @(negedge clk);
    checks++;
    if (count !== 3'd1 || frame_err !== 0) begin errors++; $display("FAIL break_recover: count=%0d fe=%b expected 1 0", count, frame_err); end
    pop(8'h7E, "break_d");
  endtask
  task automatic test_glitch;
    rxd = 0;
    repeat (20) @(negedge clk);
    repeat (2) bit_time(1'b1);
    checks++;
    if (count !== 3'd0 || {frame_err, parity_err, overrun} !== 3'b000) begin
      errors++;
      $display("FAIL glitch: count=%0d flags=%b%b%b expected 0 000", count, frame_err, parity_err, overrun);
    end
    send(8'h5A, 1, 0, 0);
    @(negedge clk);
    pop(8'h5A, "glitch_next");
  endtask
  task automatic test_parity;
    parity_en = 1;
    parity_odd = 0;
`ifdef LISA_RX_PARITY_EN
    send(8'h07, 1, 1, 1);
    @(negedge clk);
    checks++;
    if (count !== 3'd1 || parity_err !== 0) begin errors++; $display("FAIL parity_ok: count=%0d pe=%b expected 1 0", count, parity_err); end
    pop(8'h07, "parity_ok_d");
    send(8'h07, 1, 1, 0);
    @(negedge clk);
    checks++;
    if (count !== 3'd0 || parity_err !== 1) begin errors++; $display("FAIL parity_bad: count=%0d pe=%b expected 0 1", count, parity_err); end
    clear_errs;
`else
    send(8'h07, 1, 0, 0);
    @(negedge clk);
    checks++;
    if (count !== 3'd1 || parity_err !== 0) begin errors++; $display("FAIL parity_ignored: count=%0d pe=%b expected 1 0", count, parity_err); end
    pop(8'h07, "parity_ignored_d");
`endif
    parity_en = 0;
  endtask
  task automatic test_mid_reset;
    send(8'hF0, 0, 0, 0);
    bit_time(1'b1);
    send(8'h01, 1, 0, 0);
    send(8'h02, 1, 0, 0);
    checks++;
    if (count !== 3'd2 || frame_err !== 1) begin errors++; $display("FAIL pre_reset: count=%0d fe=%b expected 2 1", count, frame_err); end
    bit_time(1'b0);
    for (int i = 0; i < 3; i++) bit_time(1'b1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    repeat (2) bit_time(1'b1);
    checks++;
    if ({d, data_avail, count, frame_err, parity_err, overrun} !== 15'd0) begin
      errors++;
      $display("FAIL mid_reset: d=%h avail=%b count=%0d fe=%b pe=%b ov=%b expected all 0", d, data_avail, count, frame_err, parity_err, overrun);
    end
    send(8'h99, 1, 0, 0);
    @(negedge clk);
    checks++;
    if (count !== 3'd1 || frame_err !== 0) begin errors++; $display("FAIL post_reset: count=%0d fe=%b expected 1 0", count, frame_err); end
    pop(8'h99, "post_reset_d");
  endtask
  initial begin
    test_reset;
    test_single;
    test_overrun;
    test_break;
    test_glitch;
    test_parity;
    test_mid_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
